// File: rtl/wb2core.sv
// Wishbone B4 pipelined slave to core-style req/gnt/rvalid bridge; one request in flight per handshake.
// Latency: request one cycle after acceptance, response one cycle after rvalid; stalls while pending or full.
module wb2core #(
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int MaxOutstanding = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wb_cyc,
  input  logic            wb_stb,
  input  logic            wb_we,
  input  logic [DW/8-1:0] wb_sel,
  input  logic [AW-1:0]   wb_adr,
  input  logic [DW-1:0]   wb_dat_i,
  output logic            wb_ack,
  output logic            wb_err,
  output logic            wb_stall,
  output logic [DW-1:0]   wb_dat_o,
  output logic            core_req,
  input  logic            core_gnt,
  input  logic            core_rvalid,
  input  logic            core_err,
  output logic            core_we,
  output logic [DW/8-1:0] core_be,
  output logic [AW-1:0]   core_addr,
  output logic [DW-1:0]   core_wdata,
  input  logic [DW-1:0]   core_rdata
);
  localparam int OW = $clog2(MaxOutstanding + 1);
  localparam logic [OW-1:0] MaxOut = OW'(MaxOutstanding);

  typedef enum logic {IDLE, REQ} state_t;

  state_t            r_state, w_state_nxt;
  logic [OW-1:0]     r_out, r_stale, w_out_nxt, w_stale_nxt;
  logic              r_ack, r_err, r_we;
  logic [DW/8-1:0]   r_be;
  logic [AW-1:0]     r_addr;
  logic [DW-1:0]     r_wdata, r_dat;
  logic              w_pending, w_accept, w_grant, w_rsp, w_rsp_stale;

  assign w_pending   = (r_state == REQ);
  assign wb_stall    = w_pending | (r_out == MaxOut);
  assign w_accept    = wb_cyc & wb_stb & ~wb_stall;
  assign w_grant     = w_pending & core_gnt;
  // A response with nothing outstanding is left over from before a reset; drop it.
  assign w_rsp       = core_rvalid & (r_out != '0);
  assign w_rsp_stale = w_rsp & (r_stale != '0);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = REQ;
      REQ:     if (core_gnt) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_out_nxt = r_out;
    if (w_grant && !w_rsp)
      w_out_nxt = r_out + OW'(1);
    else if (!w_grant && w_rsp)
      w_out_nxt = r_out - OW'(1);
    w_stale_nxt = r_stale - OW'(w_rsp_stale);
    // Abort: everything still in flight after this edge becomes stale.
    if (!wb_cyc)
      w_stale_nxt = w_out_nxt + OW'(w_state_nxt == REQ);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_out   <= '0;
      r_stale <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_out   <= w_out_nxt;
      r_stale <= w_stale_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we    <= 1'b0;
      r_be    <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_accept) begin
      r_we    <= wb_we;
      r_be    <= wb_sel;
      r_addr  <= wb_adr;
      r_wdata <= wb_dat_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
      r_dat <= '0;
    end else begin
      r_ack <= w_rsp & ~w_rsp_stale & ~core_err;
      r_err <= w_rsp & ~w_rsp_stale & core_err;
      if (w_rsp && !w_rsp_stale)
        r_dat <= core_rdata;
    end
  end

  assign core_req   = w_pending;
  assign core_we    = r_we;
  assign core_be    = r_be;
  assign core_addr  = r_addr;
  assign core_wdata = r_wdata;
  assign wb_ack     = r_ack;
  assign wb_err     = r_err;
  assign wb_dat_o   = r_dat;
endmodule

// File: tb/tb_wb2core.sv
// Directed bench for wb2core: stimulus pushes expected responses, a negedge monitor pops and compares.
module tb_wb2core;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wb_cyc = 0, wb_stb = 0, wb_we = 0;
  logic [3:0]  wb_sel = '0;
  logic [31:0] wb_adr = '0, wb_dat_i = '0;
  logic        wb_ack, wb_err, wb_stall;
  logic [31:0] wb_dat_o;
  logic        core_req, core_we;
  logic        core_gnt = 0, core_rvalid = 0, core_err = 0;
  logic [3:0]  core_be;
  logic [31:0] core_addr, core_wdata;
  logic [31:0] core_rdata = '0;

  int total = 0;
  int bad = 0;
  logic [32:0] exp_q[$];

  wb2core #(.AW(32), .DW(32), .MaxOutstanding(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_sel(wb_sel),
    .wb_adr(wb_adr), .wb_dat_i(wb_dat_i), .wb_ack(wb_ack), .wb_err(wb_err),
    .wb_stall(wb_stall), .wb_dat_o(wb_dat_o),
    .core_req(core_req), .core_gnt(core_gnt), .core_rvalid(core_rvalid),
    .core_err(core_err), .core_we(core_we), .core_be(core_be),
    .core_addr(core_addr), .core_wdata(core_wdata), .core_rdata(core_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Monitor: every ack/err must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (wb_ack && wb_err) check("ack_and_err", 1, 0);
      if (wb_ack || wb_err) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rsp", {wb_err, wb_dat_o}, 0);
        end else begin
          logic [32:0] e;
          e = exp_q.pop_front();
          check("rsp_err_flag", wb_err, e[32]);
          check("rsp_data", wb_dat_o, e[31:0]);
        end
      end
    end
  end

  task automatic wb_issue(input logic [31:0] adr, input logic we, input logic [3:0] sel,
                          input logic [31:0] dat, output int waits);
    wb_cyc = 1; wb_stb = 1; wb_adr = adr; wb_we = we; wb_sel = sel; wb_dat_i = dat;
    waits = 0;
    while (wb_stall && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    check("accept_window", wb_stall, 0);
    @(negedge clk);
    wb_stb = 0;
  endtask

  task automatic rsp(input logic err, input logic [31:0] dat, input bit expect_it);
    core_rvalid = 1; core_err = err; core_rdata = dat;
    if (expect_it) exp_q.push_back({err, dat});
    @(negedge clk);
    core_rvalid = 0; core_err = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: total=%0d", total);
    $fatal(1);
  end

  initial begin
    int w;
    repeat (3) @(negedge clk);
    check("rst_req", core_req, 0);
    check("rst_stall", wb_stall, 0);
    check("rst_ack", wb_ack, 0);
    check("rst_err", wb_err, 0);
    check("rst_dat", wb_dat_o, 0);
    check("rst_addr", core_addr, 0);

    // Single read, first acceptance right after reset release
    rst_n = 1; core_gnt = 1;
    wb_issue(32'h1000, 0, 4'hF, 0, w);
    check("first_accept_wait", w, 0);
    check("rd_req", core_req, 1);
    check("rd_addr", core_addr, 32'h1000);
    check("rd_stall", wb_stall, 1);
    @(negedge clk);
    check("rd_req_one_cycle", core_req, 0);
    @(negedge clk);
    rsp(0, 32'hDEADBEEF, 1);
    @(negedge clk);
    check("rd_ack_one_cycle", wb_ack, 0);
    check("rd_dat_hold", wb_dat_o, 32'hDEADBEEF);

    // Write with grant withheld for three cycles
    core_gnt = 0;
    wb_issue(32'h2004, 1, 4'h3, 32'h12345678, w);
    for (int i = 0; i < 4; i++) begin
      check("wr_req_held", core_req, 1);
      check("wr_fields", {core_we, core_be, core_addr, core_wdata}, {1'b1, 4'h3, 32'h2004, 32'h12345678});
      check("wr_stall", wb_stall, 1);
      if (i == 3) core_gnt = 1;
      @(negedge clk);
    end
    check("wr_req_drop", core_req, 0);
    rsp(0, 32'h0, 1);
    @(negedge clk);

    // Outstanding limit
    wb_issue(32'h3000, 0, 4'hF, 0, w);
    wb_issue(32'h3004, 0, 4'hF, 0, w);
    @(negedge clk);
    check("lim_stall_full", wb_stall, 1);
    wb_stb = 1; wb_adr = 32'h3008;
    @(negedge clk);
    check("lim_still_stalled", wb_stall, 1);
    check("lim_no_req", core_req, 0);
    rsp(0, 32'hA1A1A1A1, 1);
    @(negedge clk);
    wb_stb = 0;
    check("lim_third_req", core_req, 1);
    check("lim_third_addr", core_addr, 32'h3008);
    rsp(0, 32'hA2A2A2A2, 1);
    rsp(0, 32'hA3A3A3A3, 1);
    @(negedge clk);

    // Error response
    wb_issue(32'h4000, 0, 4'hF, 0, w);
    @(negedge clk);
    rsp(1, 32'hBAD0BAD0, 1);
    @(negedge clk);

    // Abort with two reads in flight
    wb_issue(32'h5000, 0, 4'hF, 0, w);
    wb_issue(32'h5004, 0, 4'hF, 0, w);
    @(negedge clk);
    wb_cyc = 0;
    @(negedge clk);
    wb_cyc = 1;
    check("abort_stall", wb_stall, 1);
    rsp(0, 32'h11111111, 0);
    wb_issue(32'h5008, 0, 4'hF, 0, w);
    @(negedge clk);
    rsp(0, 32'h22222222, 0);
    check("stale_dat_hold", wb_dat_o, 32'hBAD0BAD0);
    rsp(0, 32'h55AA55AA, 1);
    @(negedge clk);

    // Reset while pending
    core_gnt = 0;
    wb_issue(32'h6000, 0, 4'hF, 0, w);
    check("rst_mid_req_before", core_req, 1);
    #2 rst_n = 0;
    #1;
    check("rst_mid_req", core_req, 0);
    check("rst_mid_stall", wb_stall, 0);
    check("rst_mid_addr", core_addr, 0);
    @(negedge clk);
    rst_n = 1;
    rsp(0, 32'h77777777, 0);
    repeat (2) @(negedge clk);
    check("stray_no_ack", wb_ack, 0);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
